// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO: level/address widths and parameter legality.
// No logic, no latency.
// No flow control.
package fifo_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (never less than one bit).
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Threshold and depth combinations that give meaningful flags.
  function automatic bit params_legal(input int depth, input int af_level, input int ae_level);
    return (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Write lands at the rising edge; read data follows rd_addr combinationally.
// No flow control; the caller guarantees writes only target free entries.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it maps onto plain LUTRAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with fill level, almost flags, flush and sticky error flags.
// A word pushed into an empty FIFO is on result right after the push edge; 1 word/cycle.
// rdy drops when full (no push even with a same-cycle pop); result_rdy drops when empty.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  values_rdy,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  rdy,
  output logic                  result_rdy,
  output logic [DATA_WIDTH-1:0] result,
  input  logic                  next_module_rdy,
  output logic [CW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

  if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("stream_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         level_q, level_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;

  logic                  full, empty, push, pop, ram_we;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // full/empty come only from registered level, so rdy/result_rdy never see the other side's handshake.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = values_rdy && !full;
  assign pop   = next_module_rdy && !empty;

  // Next-state for pointers, level, held output word and sticky errors; flush overrides all.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    last_d    = last_q;
    ram_we    = 1'b0;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else begin
      ram_we = push;
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        // Remember the departing word so result holds it while empty.
        last_d   = ram_rd_data;
      end
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
      err_ovf_d = err_ovf_q || (values_rdy && full);
      err_unf_d = err_unf_q || (next_module_rdy && empty);
    end
  end

  // All control state in one register bank, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      last_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      last_q    <= last_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (value),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign rdy           = !full;
  assign result_rdy    = !empty;
  assign result        = empty ? last_q : ram_rd_data;
  assign level         = level_q;
  assign almost_full   = (level_q >= AF_LVL);
  assign almost_empty  = (level_q <= AE_LVL);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed checks of stream_fifo (DEPTH=4 and DEPTH=3) plus a randomised queue scoreboard.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Backpressure is exercised through next_module_rdy and by overfilling.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        flush4 = 1'b0, vld4 = 1'b0, nmr4 = 1'b0;
  logic [31:0] val4 = '0;
  logic        rdy4, rrdy4, af4, ae4, ovf4, unf4;
  logic [31:0] res4;
  logic [2:0]  lvl4;

  // DEPTH=3 instance (non power of two)
  logic        flush3 = 1'b0, vld3 = 1'b0, nmr3 = 1'b0;
  logic [31:0] val3 = '0;
  logic        rdy3, rrdy3, af3, ae3, ovf3, unf3;
  logic [31:0] res3;
  logic [1:0]  lvl3;

  int n_assert = 0;
  int n_fail   = 0;

  stream_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u4 (
    .clk(clk), .rstn(rstn), .flush(flush4), .values_rdy(vld4), .value(val4),
    .rdy(rdy4), .result_rdy(rrdy4), .result(res4), .next_module_rdy(nmr4),
    .level(lvl4), .almost_full(af4), .almost_empty(ae4),
    .err_overflow(ovf4), .err_underflow(unf4)
  );

  stream_fifo #(.DATA_WIDTH(32), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1)) u3 (
    .clk(clk), .rstn(rstn), .flush(flush3), .values_rdy(vld3), .value(val3),
    .rdy(rdy3), .result_rdy(rrdy3), .result(res3), .next_module_rdy(nmr3),
    .level(lvl3), .almost_full(af3), .almost_empty(ae3),
    .err_overflow(ovf3), .err_underflow(unf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    int pushed, popped, cyc;
    bit do_push, do_pop;

    // ---- Reset state
    #2;
    check("rst_level", 32'(lvl4), 0);
    check("rst_rdy", 32'(rdy4), 1);
    check("rst_result_rdy", 32'(rrdy4), 0);
    check("rst_result", res4, 0);
    check("rst_af", 32'(af4), 0);
    check("rst_ae", 32'(ae4), 1);
    check("rst_ovf", 32'(ovf4), 0);
    check("rst_unf", 32'(unf4), 0);
    tick();
    rstn = 1'b1;
    tick();

    // ---- Fill to full with downstream stalled
    vld4 = 1'b1; val4 = 32'h11; tick();
    check("fill1_level", 32'(lvl4), 1);
    check("fill1_ae", 32'(ae4), 1);
    check("fill1_head", res4, 32'h11);
    val4 = 32'h22; tick();
    check("fill2_ae", 32'(ae4), 0);
    check("fill2_af", 32'(af4), 0);
    val4 = 32'h33; tick();
    check("fill3_level", 32'(lvl4), 3);
    check("fill3_af", 32'(af4), 1);
    check("fill3_rdy", 32'(rdy4), 1);
    val4 = 32'h44; tick();
    check("fill4_level", 32'(lvl4), 4);
    check("fill4_rdy", 32'(rdy4), 0);
    check("fill4_ovf", 32'(ovf4), 0);
    val4 = 32'h55; tick();
    check("ovf_flag", 32'(ovf4), 1);
    check("ovf_level", 32'(lvl4), 4);
    check("ovf_head_stable", res4, 32'h11);

    // ---- Drain on consecutive cycles
    vld4 = 1'b0; nmr4 = 1'b1;
    check("drain0", res4, 32'h11);
    tick(); check("drain1", res4, 32'h22);
    tick(); check("drain2", res4, 32'h33);
    tick(); check("drain3", res4, 32'h44);
    check("drain3_rrdy", 32'(rrdy4), 1);
    tick();
    check("drained_rrdy", 32'(rrdy4), 0);
    check("drained_ae", 32'(ae4), 1);
    check("drained_level", 32'(lvl4), 0);
    check("drained_unf_clear", 32'(unf4), 0);
    tick();
    check("unf_flag", 32'(unf4), 1);
    check("empty_result_held", res4, 32'h44);
    check("unf_level", 32'(lvl4), 0);
    nmr4 = 1'b0;

    // ---- Asynchronous reset with 3 words held
    vld4 = 1'b1;
    val4 = 32'hA1; tick();
    val4 = 32'hA2; tick();
    val4 = 32'hA3; tick();
    vld4 = 1'b0;
    check("pre_rst_level", 32'(lvl4), 3);
    #2 rstn = 1'b0;
    #1;
    check("midrst_level", 32'(lvl4), 0);
    check("midrst_rdy", 32'(rdy4), 1);
    check("midrst_rrdy", 32'(rrdy4), 0);
    check("midrst_ovf", 32'(ovf4), 0);
    check("midrst_unf", 32'(unf4), 0);
    check("midrst_result", res4, 0);
    tick();
    rstn = 1'b1;
    tick();

    // ---- Full with simultaneous pop and push attempt
    vld4 = 1'b1;
    val4 = 32'hB1; tick();
    val4 = 32'hB2; tick();
    val4 = 32'hB3; tick();
    val4 = 32'hB4; tick();
    check("fp_full", 32'(lvl4), 4);
    val4 = 32'hB5; nmr4 = 1'b1; tick();
    check("fp_level", 32'(lvl4), 3);
    check("fp_head", res4, 32'hB2);
    check("fp_rdy_back", 32'(rdy4), 1);
    nmr4 = 1'b0; tick();
    check("fp_retry_level", 32'(lvl4), 4);
    vld4 = 1'b0; nmr4 = 1'b1;
    check("fp_d0", res4, 32'hB2);
    tick(); check("fp_d1", res4, 32'hB3);
    tick(); check("fp_d2", res4, 32'hB4);
    tick(); check("fp_d3", res4, 32'hB5);
    tick(); check("fp_empty", 32'(lvl4), 0);
    nmr4 = 1'b0;

    // ---- Flush with level 2 and a word presented
    vld4 = 1'b1;
    val4 = 32'hC1; tick();
    val4 = 32'hC2; tick();
    check("fl_pre_level", 32'(lvl4), 2);
    check("fl_pre_ovf", 32'(ovf4), 1);
    flush4 = 1'b1; val4 = 32'hC3; tick();
    flush4 = 1'b0; vld4 = 1'b0;
    check("fl_level", 32'(lvl4), 0);
    check("fl_rrdy", 32'(rrdy4), 0);
    check("fl_rdy", 32'(rdy4), 1);
    check("fl_ovf_clr", 32'(ovf4), 0);
    vld4 = 1'b1; val4 = 32'hC4; tick();
    vld4 = 1'b0;
    check("fl_after_level", 32'(lvl4), 1);
    check("fl_after_head", res4, 32'hC4);
    nmr4 = 1'b1; tick(); nmr4 = 1'b0;
    check("fl_after_empty", 32'(lvl4), 0);

    // ---- Streaming through DEPTH=3
    vld3 = 1'b1; nmr3 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      val3 = 32'(i);
      tick();
      check($sformatf("stream_data_%0d", i), res3, 32'(i));
      check($sformatf("stream_level_%0d", i), 32'(lvl3), 1);
    end
    vld3 = 1'b0; tick(); nmr3 = 1'b0;
    check("stream_end_level", 32'(lvl3), 0);
    check("stream_end_rrdy", 32'(rrdy3), 0);

    // ---- Random backpressure against a queue model
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 1000 && cyc < 20000) begin
      vld4 = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      val4 = $urandom;
      nmr4 = ($urandom_range(0, 2) != 0);
      do_push = vld4 && (q.size() < 4);
      do_pop  = nmr4 && (q.size() > 0);
      check("sb_level", 32'(lvl4), 32'(q.size()));
      if (do_pop) check("sb_data", res4, q[0]);
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(val4);
        pushed++;
      end
      cyc++;
    end
    vld4 = 1'b0; nmr4 = 1'b0;
    check("sb_all_words", 32'(popped), 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
